// File: rtl/router_port_arbiter_if.sv
// router_port_arbiter_if: input stream bundle plus registered output channel of one router port
interface router_port_arbiter_if #(
   parameter int NUM_CHANNELS  = 5,
   parameter int CHANNEL_WIDTH = 64
);
   logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0] rx_data;
   logic [NUM_CHANNELS-1:0]               rx_valid;
   logic [NUM_CHANNELS-1:0]               rx_ready;
   logic [CHANNEL_WIDTH-1:0]              tx_data;
   logic                                  tx_valid;
   logic                                  tx_ready;
   logic                                  busy;
   logic [$clog2(NUM_CHANNELS)-1:0]       lock_ch;
   modport master (output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid, busy, lock_ch);
   modport slave  (input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid, busy, lock_ch);
endinterface

// File: rtl/router_port_arbiter.sv
// router_port_arbiter: round-robin, packet-locking arbiter feeding one registered router output port
module router_port_arbiter #(
   parameter int NUM_CHANNELS  = 5,
   parameter int CHANNEL_WIDTH = 64,
   parameter int DEST_WIDTH    = 8,
   parameter int PORT_ID       = 0,
   parameter int MORE_BIT      = CHANNEL_WIDTH-DEST_WIDTH-1
) (
   input logic clk,
   input logic reset,
   router_port_arbiter_if.slave port
);
   localparam int CW = $clog2(NUM_CHANNELS);
   typedef enum logic {IDLE, LOCK} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] ptr, gnt, idx;
   logic [NUM_CHANNELS-1:0] req;
   logic [CHANNEL_WIDTH-1:0] word;
   logic gnt_ok, load_ok, xfer, tx_valid_nxt;
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_CHANNELS; i++)
         req[i] = port.rx_valid[i] && port.rx_data[CHANNEL_WIDTH*i+CHANNEL_WIDTH-1 -: DEST_WIDTH] == DEST_WIDTH'(PORT_ID);
   end
   // descending scan so the nearest requester after ptr is written last and wins
   always_comb begin
      gnt = port.lock_ch;
      gnt_ok = req[port.lock_ch];
      idx = '0;
      if (state == IDLE) begin
         gnt_ok = 1'b0;
         for (int k = NUM_CHANNELS; k >= 1; k--) begin
            idx = CW'((int'(ptr) + k) % NUM_CHANNELS);
            if (req[idx]) begin
               gnt = idx;
               gnt_ok = 1'b1;
            end
         end
      end
   end
   always_comb begin
      word = '0;
      for (int i = 0; i < NUM_CHANNELS; i++)
         if (gnt == CW'(i)) word = port.rx_data[CHANNEL_WIDTH*i +: CHANNEL_WIDTH];
   end
   always_comb begin
      load_ok = !port.tx_valid || port.tx_ready;
      xfer = reset && gnt_ok && load_ok;
      tx_valid_nxt = xfer || (port.tx_valid && !port.tx_ready);
      state_nxt = xfer ? (word[MORE_BIT] ? LOCK : IDLE) : state;
   end
   assign port.rx_ready = xfer ? NUM_CHANNELS'(1) << gnt : '0;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         ptr <= CW'(NUM_CHANNELS-1);
         port.lock_ch <= '0;
         port.tx_data <= '0;
         port.tx_valid <= 1'b0;
         port.busy <= 1'b0;
      end else begin
         state <= state_nxt;
         port.tx_valid <= tx_valid_nxt;
         port.busy <= tx_valid_nxt || state_nxt == LOCK || |req;
         if (xfer) begin
            port.tx_data <= word;
            ptr <= gnt;
            port.lock_ch <= gnt;
         end
      end
   end
endmodule

// File: tb/tb_router_port_arbiter.sv
// tb_router_port_arbiter: directed vectors for the port arbiter instance serving destination 2
module tb_router_port_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   int tx_cnt = 0;
   int base;
   int rr_exp [6] = '{0, 1, 3, 0, 1, 3};
   router_port_arbiter_if #(.NUM_CHANNELS(5), .CHANNEL_WIDTH(64)) port ();
   router_port_arbiter #(.NUM_CHANNELS(5), .CHANNEL_WIDTH(64), .DEST_WIDTH(8), .PORT_ID(2)) dut (
      .clk(clk),
      .reset(reset),
      .port(port)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (reset && port.tx_valid && port.tx_ready) tx_cnt++;
   function automatic logic [63:0] w(input int dest, input bit more, input int pay);
      return {8'(dest), more, 55'(pay)};
   endfunction
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic set_ch(input int i, input bit v, input logic [63:0] d);
      port.rx_valid[i] = v;
      port.rx_data[64*i +: 64] = d;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      port.rx_data = '0;
      port.rx_valid = '0;
      port.tx_ready = 1'b1;
      // reset with every channel requesting
      for (int i = 0; i < 5; i++) set_ch(i, 1'b1, w(2, 1'b0, 'h100 + i));
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("rst_rx_ready", port.rx_ready, 5'b00000);
         step();
         chk("rst_tx_valid", port.tx_valid, 1'b0);
         chk("rst_busy", port.busy, 1'b0);
      end
      reset = 1'b1;
      #1;
      chk("rst_first_grant", port.rx_ready, 5'b00001);
      step();
      chk("rst_first_word", port.tx_data, w(2, 1'b0, 'h100));
      // round robin among 0,1,3
      port.rx_valid = '0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      set_ch(0, 1'b1, w(2, 1'b0, 0));
      set_ch(1, 1'b1, w(2, 1'b0, 1));
      set_ch(3, 1'b1, w(2, 1'b0, 3));
      #1;
      chk("rr_tx_idle", port.tx_valid, 1'b0);
      for (int i = 0; i < 6; i++) begin
         chk("rr_grant", port.rx_ready, 5'(1) << rr_exp[i]);
         step();
         chk("rr_tx_valid", port.tx_valid, 1'b1);
         chk("rr_tx_data", port.tx_data, w(2, 1'b0, rr_exp[i]));
      end
      chk("rr_busy", port.busy, 1'b1);
      port.rx_valid = '0;
      step();
      chk("rr_drain_valid", port.tx_valid, 1'b0);
      chk("rr_drain_busy", port.busy, 1'b0);
      // destination filter: ch1 targets port 3, ch4 targets port 2
      set_ch(1, 1'b1, w(3, 1'b0, 'h11));
      set_ch(4, 1'b1, w(2, 1'b0, 'h44));
      #1;
      chk("flt_grant", port.rx_ready, 5'b10000);
      step();
      chk("flt_tx_data", port.tx_data, w(2, 1'b0, 'h44));
      set_ch(4, 1'b0, '0);
      #1;
      chk("flt_ch1_held", port.rx_ready, 5'b00000);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("flt_ch1_idle", port.rx_ready, 5'b00000);
      end
      chk("flt_busy", port.busy, 1'b0);
      chk("flt_tx_valid", port.tx_valid, 1'b0);
      // packet lock on ch1 while ch0 keeps requesting
      set_ch(0, 1'b1, w(2, 1'b0, 'h10));
      set_ch(1, 1'b1, w(2, 1'b1, 'h20));
      #1;
      chk("pkt_ch0_first", port.rx_ready, 5'b00001);
      step();
      chk("pkt_ch0_data", port.tx_data, w(2, 1'b0, 'h10));
      chk("pkt_lock_ch0", port.lock_ch, 0);
      chk("pkt_beat0_grant", port.rx_ready, 5'b00010);
      step();
      chk("pkt_beat0_data", port.tx_data, w(2, 1'b1, 'h20));
      chk("pkt_lock_ch1", port.lock_ch, 1);
      set_ch(1, 1'b1, w(2, 1'b1, 'h21));
      #1;
      chk("pkt_beat1_grant", port.rx_ready, 5'b00010);
      step();
      chk("pkt_beat1_data", port.tx_data, w(2, 1'b1, 'h21));
      set_ch(1, 1'b0, w(2, 1'b0, 'h22));
      #1;
      chk("pkt_lock_stall", port.rx_ready, 5'b00000);
      step();
      chk("pkt_gap_valid", port.tx_valid, 1'b0);
      chk("pkt_gap_busy", port.busy, 1'b1);
      chk("pkt_gap_lock", port.lock_ch, 1);
      set_ch(1, 1'b1, w(2, 1'b0, 'h22));
      #1;
      chk("pkt_beat2_grant", port.rx_ready, 5'b00010);
      step();
      chk("pkt_beat2_data", port.tx_data, w(2, 1'b0, 'h22));
      set_ch(1, 1'b0, '0);
      #1;
      chk("pkt_release", port.rx_ready, 5'b00001);
      step();
      chk("pkt_ch0_after", port.tx_data, w(2, 1'b0, 'h10));
      chk("pkt_lock_after", port.lock_ch, 0);
      set_ch(0, 1'b0, '0);
      step();
      // backpressure on ch3
      base = tx_cnt;
      set_ch(3, 1'b1, w(2, 1'b0, 'h30));
      step();
      chk("bp_first", port.tx_data, w(2, 1'b0, 'h30));
      port.tx_ready = 1'b0;
      set_ch(3, 1'b1, w(2, 1'b0, 'h31));
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("bp_rx_ready", port.rx_ready, 5'b00000);
         step();
         chk("bp_hold_data", port.tx_data, w(2, 1'b0, 'h30));
         chk("bp_hold_valid", port.tx_valid, 1'b1);
      end
      port.tx_ready = 1'b1;
      #1;
      chk("bp_resume_grant", port.rx_ready, 5'b01000);
      step();
      chk("bp_replace_data", port.tx_data, w(2, 1'b0, 'h31));
      chk("bp_no_bubble", port.tx_valid, 1'b1);
      set_ch(3, 1'b0, '0);
      step();
      chk("bp_drain", port.tx_valid, 1'b0);
      chk("bp_count", tx_cnt - base, 2);
      // reset in the middle of a ch2 packet
      set_ch(2, 1'b1, w(2, 1'b1, 'h40));
      #1;
      chk("mid_grant_ch2", port.rx_ready, 5'b00100);
      step();
      chk("mid_lock_ch2", port.lock_ch, 2);
      reset = 1'b0;
      set_ch(2, 1'b1, w(2, 1'b1, 'h41));
      set_ch(0, 1'b1, w(2, 1'b0, 'h50));
      #1;
      chk("mid_rst_rx_ready", port.rx_ready, 5'b00000);
      step();
      chk("mid_rst_valid", port.tx_valid, 1'b0);
      chk("mid_rst_busy", port.busy, 1'b0);
      chk("mid_rst_lock", port.lock_ch, 0);
      step();
      reset = 1'b1;
      #1;
      chk("mid_idle_grant", port.rx_ready, 5'b00001);
      step();
      chk("mid_ch0_data", port.tx_data, w(2, 1'b0, 'h50));
      port.rx_valid = '0;
      step();
      step();
      chk("mid_idle_busy", port.busy, 1'b0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule

// File: doc/router_port_arbiter.md
# router_port_arbiter

Output-port arbiter for the stage-controller router: shares one outgoing channel among NUM_CHANNELS incoming streams (index 0 = controller/upstream, 1..N-1 = downstream FPGAs). It accepts only words whose destination field equals PORT_ID, grants inputs in round-robin order, and keeps multi-word packets contiguous. Its output is registered into the per-port output FIFO. One instance sits on each router output port, and the instances' busy flags feed the controller's router_busy.

## Interface
- NUM_CHANNELS, 5: number of input streams
- CHANNEL_WIDTH, 64: word width
- DEST_WIDTH, 8: destination field width, at bits [CHANNEL_WIDTH-1 -: DEST_WIDTH]
- PORT_ID, 0: destination value this port serves
- MORE_BIT, CHANNEL_WIDTH-DEST_WIDTH-1: bit index of the "more words follow" flag

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low; registers clear on a rising clk edge while reset=0
- rx_data  in  CHANNEL_WIDTH*NUM_CHANNELS  input words, channel i at [CHANNEL_WIDTH*i +: CHANNEL_WIDTH]
- rx_valid  in  NUM_CHANNELS  per-channel valid
- rx_ready  out  NUM_CHANNELS  per-channel accept; combinational
- tx_data  out  CHANNEL_WIDTH  registered output word, passed unmodified
- tx_valid  out  1  registered output valid
- tx_ready  in  1  downstream accept
- busy  out  1  registered; port has work in flight
- lock_ch  out  $clog2(NUM_CHANNELS)  debug: current or last granted channel

## Operation
- Request: req[i] = rx_valid[i] && (rx_data dest field of channel i == PORT_ID). Words for other ports are never consumed by this instance.
- Load enable: load_ok = !tx_valid || tx_ready. The output register is a single stage with full throughput.
- FSM, two states:
  - IDLE: the grant goes to the first requesting channel, searching cyclically from ptr+1 through ptr+NUM_CHANNELS (mod NUM_CHANNELS).
  - LOCK: the grant is fixed to lock_ch. Requests from other channels are ignored.
- Transfer: rx_ready[g] = req[g] && load_ok for the granted channel g. All other rx_ready bits are 0, and all are 0 when nothing is granted.
- On a transfer:
  - tx_data <= word, tx_valid <= 1, ptr <= g, lock_ch <= g.
  - If the word's MORE_BIT = 1, the next state is LOCK.
  - If MORE_BIT = 0, the next state is IDLE.
- With no transfer: if tx_ready && tx_valid, then tx_valid <= 0. tx_data holds its value.
- In LOCK, while the locked channel has no matching valid word, no other channel is served. The lock releases only on a transfer with MORE_BIT = 0.
- Pointer semantics: the channel served last has the lowest priority on the next arbitration. A lock does not advance fairness beyond the final beat.
- busy <= next tx_valid || (next state == LOCK) || |req (evaluated on the current cycle).

## Timing
- Reset values:
  - tx_valid = 0, tx_data = 0, busy = 0.
  - State = IDLE, ptr = NUM_CHANNELS-1 (so channel 0 wins the first tie), lock_ch = 0.
  - rx_ready = 0 while reset=0.
- Latency: accept in cycle n gives tx_valid=1 in cycle n+1. Sustained throughput is 1 word/cycle while tx_ready=1.
- Backpressure: when tx_valid=1 and tx_ready=0, all rx_ready are 0, and tx_data/tx_valid hold stable until accepted.
- Simultaneous tx_ready and a new transfer in the same cycle: the new word replaces the old one, tx_valid stays 1, and there is no bubble.
- A non-matching destination on the locked channel during LOCK is a protocol error. The word is not consumed and the port stalls. No recovery except reset.
- Reset asserted mid-packet: the FSM returns to IDLE and the buffered word is dropped. There is no partial-packet state after reset.
- rx_ready never depends on tx_valid/tx_ready of other ports. It has no combinational path from rx_ready to rx_valid.

## Test plan
- **Reset:**
  - Stimulus: hold reset=0 for 3 cycles with all rx_valid=1, then release.
  - Required: tx_valid=0, busy=0, rx_ready=0 during reset. First grant after release goes to ch0.
- **Round robin:**
  - Stimulus: PORT_ID=2; channels 0,1,3 continuously present single-word packets with dest=2, MORE=0; tx_ready=1.
  - Required: tx order ch0, ch1, ch3, ch0, ch1, ch3, one word per cycle, first tx_valid one cycle after the first accept.
- **Destination filter:**
  - Stimulus: ch1 presents dest=3; ch4 presents dest=2.
  - Required: only rx_ready[4] asserts; ch1's word remains unconsumed indefinitely.
- **Packet lock:**
  - Stimulus: ch1 sends 3 words with MORE=1,1,0; ch0 requests continuously.
  - Required: the 3 ch1 words appear contiguously on tx; ch0 is served on the next cycle; lock_ch=1 during the packet.
- **Backpressure:**
  - Stimulus: tx_ready=0 for 4 cycles with tx_valid=1, then 1.
  - Required: tx_data is unchanged and rx_ready=0 during the stall; no word is lost or duplicated (scoreboard count matches).
- **Mid-packet reset:**
  - Stimulus: assert reset after the first word of a MORE=1 packet from ch2, then release.
  - Required: IDLE after reset; ch0 request is granted first; busy=0 once idle.
